// File: rtl/sprite_layer.sv
// Multi-sprite hit test with double-buffered positions, shared animation
// frame, fixed priority and per-frame sprite-vs-sprite collision flags.
module sprite_layer #(
  parameter int N_SPRITES   = 4,
  parameter int COORD_W     = 8,
  parameter int INDEX_W     = 7,
  parameter int SIZE        = 16,
  parameter int ANIM_FRAMES = 4,
  parameter int ANIM_DIV    = 8,
  localparam int SEL_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FRAME_TICK,
  input  logic                 WR_EN,
  input  logic [SEL_W-1:0]     WR_SEL,
  input  logic [COORD_W-1:0]   WR_X,
  input  logic [COORD_W-1:0]   WR_Y,
  input  logic [INDEX_W-1:0]   WR_BASE,
  input  logic                 WR_VIS,
  input  logic                 DRAW_VALID,
  input  logic [2*COORD_W-1:0] DRAW_COORD,
  output logic                 PIX_VALID,
  output logic                 PIX_HIT,
  output logic [SEL_W-1:0]     PIX_SEL,
  output logic [INDEX_W-1:0]   PIX_INDEX,
  output logic [N_SPRITES-1:0] COLLIDE
);

  localparam int FR_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [COORD_W-1:0] sh_x_q [N_SPRITES];
  logic [COORD_W-1:0] sh_y_q [N_SPRITES];
  logic [INDEX_W-1:0] sh_base_q [N_SPRITES];
  logic [N_SPRITES-1:0] sh_vis_q;
  logic [COORD_W-1:0] act_x_q [N_SPRITES];
  logic [COORD_W-1:0] act_y_q [N_SPRITES];
  logic [INDEX_W-1:0] act_base_q [N_SPRITES];
  logic [N_SPRITES-1:0] act_vis_q;

  logic [DIV_W-1:0] div_q, div_d;
  logic [FR_W-1:0]  frame_q, frame_d;

  logic [N_SPRITES-1:0] acc_q, acc_d;
  logic [N_SPRITES-1:0] coll_q, coll_d;
  logic [N_SPRITES-1:0] hits, coll_hits;
  logic                 found;
  logic [SEL_W-1:0]     win_sel;
  logic [INDEX_W-1:0]   win_idx;
  logic                 wr_ok;

  logic                 pv_q, ph_q;
  logic [SEL_W-1:0]     ps_q;
  logic [INDEX_W-1:0]   pi_q;

  assign wr_ok = 32'(WR_SEL) < 32'(N_SPRITES);

  // Commit samples the shadow before this cycle's write lands
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x_q[i]     <= '0;
        sh_y_q[i]     <= '0;
        sh_base_q[i]  <= (i == 0) ? INDEX_W'(1) : '0;
        act_x_q[i]    <= '0;
        act_y_q[i]    <= '0;
        act_base_q[i] <= (i == 0) ? INDEX_W'(1) : '0;
      end
      sh_vis_q  <= N_SPRITES'(1);
      act_vis_q <= N_SPRITES'(1);
    end else begin
      if (WR_EN && wr_ok) begin
        sh_x_q[WR_SEL]    <= WR_X;
        sh_y_q[WR_SEL]    <= WR_Y;
        sh_base_q[WR_SEL] <= WR_BASE;
        sh_vis_q[WR_SEL]  <= WR_VIS;
      end
      if (FRAME_TICK) begin
        for (int i = 0; i < N_SPRITES; i++) begin
          act_x_q[i]    <= sh_x_q[i];
          act_y_q[i]    <= sh_y_q[i];
          act_base_q[i] <= sh_base_q[i];
        end
        act_vis_q <= sh_vis_q;
      end
    end
  end

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (FRAME_TICK) begin
      if (div_q == DIV_W'(ANIM_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == FR_W'(ANIM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Bounds widened by one bit so a sprite near the edge never wraps
  always_comb begin
    logic [COORD_W:0] lx, hx, ly, hy, px, py;
    hits = '0;
    lx = '0; hx = '0; ly = '0; hy = '0;
    px = {1'b0, DRAW_COORD[COORD_W-1:0]};
    py = {1'b0, DRAW_COORD[2*COORD_W-1:COORD_W]};
    for (int i = 0; i < N_SPRITES; i++) begin
      lx = {1'b0, act_x_q[i]};
      ly = {1'b0, act_y_q[i]};
      hx = lx + (COORD_W+1)'(SIZE - 1);
      hy = ly + (COORD_W+1)'(SIZE - 1);
      hits[i] = act_vis_q[i] && px >= lx && px <= hx
                && py >= ly && py <= hy;
    end
  end

  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (hits[i] && !found) begin
        found   = 1'b1;
        win_sel = SEL_W'(i);
      end
    end
    win_idx = act_base_q[win_sel] + INDEX_W'(frame_q);
  end

  always_comb begin
    coll_hits = '0;
    if (DRAW_VALID && |(hits & (hits - N_SPRITES'(1))))
      coll_hits = hits;
    acc_d  = acc_q | coll_hits;
    coll_d = coll_q;
    if (FRAME_TICK) begin
      coll_d = acc_d;
      acc_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q   <= '0;
      frame_q <= '0;
      acc_q   <= '0;
      coll_q  <= '0;
      pv_q    <= 1'b0;
      ph_q    <= 1'b0;
      ps_q    <= '0;
      pi_q    <= '0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
      acc_q   <= acc_d;
      coll_q  <= coll_d;
      pv_q    <= DRAW_VALID;
      ph_q    <= DRAW_VALID && found;
      ps_q    <= (DRAW_VALID && found) ? win_sel : '0;
      pi_q    <= (DRAW_VALID && found) ? win_idx : '0;
    end
  end

  assign PIX_VALID = pv_q;
  assign PIX_HIT   = ph_q;
  assign PIX_SEL   = ps_q;
  assign PIX_INDEX = pi_q;
  assign COLLIDE   = coll_q;

endmodule

// File: tb/tb_sprite_layer.sv
// Scoreboard bench for sprite_layer: stimulus pushes expected pixels,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_sprite_layer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FRAME_TICK = 1'b0;
  logic        WR_EN = 1'b0;
  logic [1:0]  WR_SEL = '0;
  logic [7:0]  WR_X = '0;
  logic [7:0]  WR_Y = '0;
  logic [6:0]  WR_BASE = '0;
  logic        WR_VIS = 1'b0;
  logic        DRAW_VALID = 1'b0;
  logic [15:0] DRAW_COORD = '0;
  logic        PIX_VALID;
  logic        PIX_HIT;
  logic [1:0]  PIX_SEL;
  logic [6:0]  PIX_INDEX;
  logic [3:0]  COLLIDE;

  sprite_layer dut (
    .CLK(CLK), .RESET(RESET), .FRAME_TICK(FRAME_TICK),
    .WR_EN(WR_EN), .WR_SEL(WR_SEL), .WR_X(WR_X), .WR_Y(WR_Y),
    .WR_BASE(WR_BASE), .WR_VIS(WR_VIS),
    .DRAW_VALID(DRAW_VALID), .DRAW_COORD(DRAW_COORD),
    .PIX_VALID(PIX_VALID), .PIX_HIT(PIX_HIT), .PIX_SEL(PIX_SEL),
    .PIX_INDEX(PIX_INDEX), .COLLIDE(COLLIDE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(negedge CLK) begin
    if (mon_en && !RESET) begin
      if (PIX_VALID) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pix: PIX_VALID with empty scoreboard");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(e.nm, {PIX_HIT, PIX_SEL, PIX_INDEX}, e.v);
        end
      end else begin
        chk("idle_zero", {PIX_HIT, PIX_SEL, PIX_INDEX}, 0);
      end
    end
  end

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    FRAME_TICK = 1'b1;
    adv();
    FRAME_TICK = 1'b0;
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] x, input logic [7:0] y,
                    input logic [6:0] b, input logic v, input logic tk);
    WR_EN = 1'b1; WR_SEL = s; WR_X = x; WR_Y = y;
    WR_BASE = b; WR_VIS = v; FRAME_TICK = tk;
    adv();
    WR_EN = 1'b0; FRAME_TICK = 1'b0;
  endtask

  task automatic px(input string nm, input logic [7:0] y, input logic [7:0] x,
                    input logic h, input logic [1:0] s, input logic [6:0] i,
                    input logic tk);
    exp_t e;
    e.nm = nm;
    e.v  = {h, s, i};
    sb.push_back(e);
    DRAW_VALID = 1'b1;
    DRAW_COORD = {y, x};
    FRAME_TICK = tk;
    adv();
    DRAW_VALID = 1'b0;
    FRAME_TICK = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d pixels never returned, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [6:0] ex;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out", {PIX_VALID, PIX_HIT, PIX_SEL, PIX_INDEX, COLLIDE}, 0);
    RESET = 1'b0;
    adv();
    mon_en = 1'b1;

    // T1: default sprite 0 visible at origin
    tick();
    px("t1_hero", 5, 5, 1, 0, 1, 0);

    // sprite 1 shadow write, visible only after T2
    wr(1, 20, 20, 10, 1, 0);
    px("t2_pre", 25, 25, 0, 0, 0, 0);
    tick();
    px("t2_in", 25, 25, 1, 1, 10, 0);
    px("t2_x35", 25, 35, 1, 1, 10, 0);
    px("t2_x36", 25, 36, 0, 0, 0, 0);

    // T3..T5: overlap, priority and collision reporting
    wr(1, 0, 0, 10, 1, 0);
    tick();
    px("t3_pri", 3, 3, 1, 0, 1, 0);
    drain();
    chk("t3_coll_pre", COLLIDE, 0);
    wr(1, 100, 100, 10, 1, 0);
    tick();
    chk("t3_coll", COLLIDE, 4'b0011);
    px("t3_sep", 3, 3, 1, 0, 1, 0);
    tick();
    chk("t3_coll_clr", COLLIDE, 0);

    // T6..T32: animation wrap with BASE=126
    wr(0, 0, 0, 126, 1, 0);
    tick();
    px("t4_t6", 5, 5, 1, 0, 126, 0);
    tick();
    px("t4_tickcyc", 5, 5, 1, 0, 126, 1);
    px("t4_t8", 5, 5, 1, 0, 127, 0);
    for (int t = 9; t <= 32; t++) begin
      tick();
      if (t == 16 || t == 24 || t == 32) begin
        case (t)
          16: ex = 7'd0;
          24: ex = 7'd1;
          default: ex = 7'd126;
        endcase
        px($sformatf("t4_t%0d", t), 5, 5, 1, 0, ex, 0);
      end
    end

    // T33: right-edge sprite must not wrap to X=0
    wr(2, 250, 200, 50, 1, 0);
    tick();
    px("t5_x255", 205, 255, 1, 2, 50, 0);
    px("t5_x250", 205, 250, 1, 2, 50, 0);
    px("t5_x249", 205, 249, 0, 0, 0, 0);
    for (int x = 0; x <= 9; x++)
      px($sformatf("t5_x%0d", x), 205, 8'(x), 0, 0, 0, 0);

    // T34: write coincident with tick stays in shadow
    wr(3, 60, 60, 20, 1, 1);
    px("t6_wrtick", 65, 65, 0, 0, 0, 0);
    tick();
    px("t6_after", 65, 65, 1, 3, 20, 0);
    wr(1, 60, 60, 10, 1, 0);
    tick();
    drain();
    chk("t6_coll_none", COLLIDE, 0);
    px("t6_tickpix", 65, 65, 1, 1, 10, 1);
    chk("t6_coll_tickpix", COLLIDE, 4'b1010);
    drain();

    // reset in the middle of a pixel stream
    mon_en = 1'b0;
    DRAW_VALID = 1'b1;
    DRAW_COORD = {8'd65, 8'd65};
    adv();
    adv();
    chk("rst_pre_valid", {PIX_VALID, PIX_HIT}, 2'b11);
    RESET = 1'b1;
    #1;
    chk("rst_async", {PIX_VALID, PIX_HIT, PIX_SEL, PIX_INDEX, COLLIDE}, 0);
    adv();
    chk("rst_edge", {PIX_VALID, PIX_HIT, PIX_SEL, PIX_INDEX, COLLIDE}, 0);
    DRAW_VALID = 1'b0;
    RESET = 1'b0;
    adv();
    mon_en = 1'b1;
    chk("rst_coll", COLLIDE, 0);
    px("rst_s3_gone", 65, 65, 0, 0, 0, 0);
    tick();
    px("rst_hero", 5, 5, 1, 0, 1, 0);
    drain();
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
